// File: rtl/bht_ctx_pkg.sv
// Shared types and helpers for the multi-context branch history table.
package bht_ctx_pkg;

  localparam int unsigned VLEN        = 39;
  localparam int unsigned IPF_DEFAULT = 2;
  localparam int unsigned CTX_IDX_W   = 3;

  typedef logic [CTX_IDX_W-1:0] ctx_idx_t;
  typedef logic [1:0]           bht_ctr_t;

  typedef struct packed {
    logic     valid;
    bht_ctr_t ctr;
  } bht_cell_t;

  typedef bht_cell_t [IPF_DEFAULT-1:0] bht_row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } copy_state_e;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  localparam bht_cell_t CELL_RESET = '{valid: 1'b0, ctr: 2'b01};

  function automatic int unsigned ctx_idx_w(input int unsigned nr_ctx);
    return (nr_ctx > 1) ? 32'($clog2(nr_ctx)) : 32'd1;
  endfunction

  function automatic int unsigned row_idx_w(input int unsigned nr_entries, input int unsigned ipf);
    return 32'($clog2(nr_entries / ipf));
  endfunction

  function automatic int unsigned col_idx_w(input int unsigned ipf);
    return 32'($clog2(ipf));
  endfunction

  function automatic logic ctx_ok(input ctx_idx_t c, input int unsigned nr_ctx);
    return 32'(c) < nr_ctx;
  endfunction

  // 2-bit saturating counter step.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bht_ctx_copy_fsm.sv
// Background context copy sequencer: walks every row once from src to dst.
module bht_ctx_copy_fsm
  import bht_ctx_pkg::*;
#(
  parameter int unsigned NR_CTX = 2,
  parameter int unsigned ROWS   = 512,
  parameter int unsigned CTX_W  = 1,
  parameter int unsigned ROW_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req,
  input  logic [CTX_W-1:0] req_src,
  input  logic [CTX_W-1:0] req_dst,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] row,
  output logic [CTX_W-1:0] src,
  output logic [CTX_W-1:0] dst
);

  copy_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CTX_W-1:0] src_q, src_d, dst_q, dst_d;
  logic             req_ok;

  // Degenerate requests skip the data move but still signal completion.
  assign req_ok = (req_src != req_dst)
                & ctx_ok(ctx_idx_t'(req_src), NR_CTX)
                & ctx_ok(ctx_idx_t'(req_dst), NR_CTX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy    <= (state_d == COPY);
      done    <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          src_d   = req_src;
          dst_d   = req_dst;
          row_d   = '0;
          state_d = req_ok ? COPY : DONE;
        end
      end
      COPY: begin
        row_d = row_q + 1'b1;
        if (row_q == ROW_W'(ROWS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign row = row_q;
  assign src = src_q;
  assign dst = dst_q;

endmodule

// File: rtl/bht_ctx_bank.sv
// Multi-context 2-bit-counter BHT with background context copy.
// Optional BHT_CTX_PERF_EN adds per-context update and copy-completion counters.
module bht_ctx_bank
  import bht_ctx_pkg::*;
#(
  parameter  int unsigned NR_ENTRIES      = 1024,
  parameter  int unsigned NR_CTX          = 2,
  parameter  int unsigned INSTR_PER_FETCH = IPF_DEFAULT,
  localparam int unsigned CTX_W           = ctx_idx_w(NR_CTX)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   debug_mode_i,
  input  logic            [CTX_W-1:0]            ctx_sel_i,
  input  logic            [VLEN-1:0]             vpc_i,
  input  bht_update_t                            bht_update_i,
  output bht_prediction_t [INSTR_PER_FETCH-1:0]  bht_prediction_o,
  input  logic                                   copy_req_i,
  input  logic            [CTX_W-1:0]            copy_src_i,
  input  logic            [CTX_W-1:0]            copy_dst_i,
  output logic                                   copy_busy_o,
  output logic                                   copy_done_o,
  output logic            [CTX_W-1:0]            active_ctx_o
`ifdef BHT_CTX_PERF_EN
  ,
  output logic            [NR_CTX-1:0][15:0]     perf_upd_cnt_o,
  output logic            [15:0]                 perf_copy_cnt_o
`endif
);

  localparam int unsigned ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_W = row_idx_w(NR_ENTRIES, INSTR_PER_FETCH);
  localparam int unsigned COL_W = col_idx_w(INSTR_PER_FETCH);

  typedef bht_cell_t [INSTR_PER_FETCH-1:0] row_t;
  localparam row_t ROW_RESET = {INSTR_PER_FETCH{CELL_RESET}};

  row_t             mem_q [NR_CTX][ROWS];
  logic [CTX_W-1:0] active_ctx_q;
  logic [CTX_W-1:0] ctx_q;
  bht_update_t      update_q;

  logic             copy_busy, copy_done;
  logic [ROW_W-1:0] copy_row;
  logic [CTX_W-1:0] copy_src, copy_dst;

  bht_ctx_copy_fsm #(
    .NR_CTX (NR_CTX),
    .ROWS   (ROWS),
    .CTX_W  (CTX_W),
    .ROW_W  (ROW_W)
  ) i_copy_fsm (
    .clk     (clk_i),
    .rst     (rst_i),
    .flush   (flush_i),
    .req     (copy_req_i),
    .req_src (copy_src_i),
    .req_dst (copy_dst_i),
    .busy    (copy_busy),
    .done    (copy_done),
    .row     (copy_row),
    .src     (copy_src),
    .dst     (copy_dst)
  );

  // Out-of-range selects leave the active context unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_ctx_q <= '0;
    end else if (ctx_ok(ctx_idx_t'(ctx_sel_i), NR_CTX)) begin
      active_ctx_q <= ctx_sel_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      update_q <= '0;
      ctx_q    <= '0;
    end else begin
      update_q <= '{valid: bht_update_i.valid & ~flush_i & ~debug_mode_i,
                    pc:    bht_update_i.pc,
                    taken: bht_update_i.taken};
      ctx_q    <= active_ctx_q;
    end
  end

  logic [ROW_W-1:0] upd_row;
  logic [COL_W-1:0] upd_col;
  logic             upd_en;
  row_t             upd_new_row;
  bht_cell_t        upd_cell;

  assign upd_row = update_q.pc[1+COL_W +: ROW_W];
  assign upd_col = update_q.pc[1 +: COL_W];
  assign upd_en  = update_q.valid & ~debug_mode_i & ~flush_i
                 & ~(copy_busy & (ctx_q == copy_dst));

  always_comb begin
    upd_new_row        = mem_q[ctx_q][upd_row];
    upd_cell           = upd_new_row[upd_col];
    upd_cell.valid     = 1'b1;
    upd_cell.ctr       = ctr_next(upd_cell.ctr, update_q.taken);
    upd_new_row[upd_col] = upd_cell;
  end

  // An update landing on the row being copied this cycle is carried along to dst.
  logic fwd;
  row_t copy_data;

  assign fwd       = upd_en & (ctx_q == copy_src) & (upd_row == copy_row);
  assign copy_data = fwd ? upd_new_row : mem_q[copy_src][copy_row];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NR_CTX; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[c][r] <= ROW_RESET;
        end
      end
    end else if (flush_i) begin
      for (int c = 0; c < NR_CTX; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            mem_q[c][r][i].valid <= 1'b0;
          end
        end
      end
    end else begin
      if (upd_en)    mem_q[ctx_q][upd_row]     <= upd_new_row;
      if (copy_busy) mem_q[copy_dst][copy_row] <= copy_data;
    end
  end

  // Lookup hides a destination context whose contents are still being rebuilt.
  logic [ROW_W-1:0] pred_idx;
  row_t             pred_row;
  logic             pred_blank;

  assign pred_idx   = vpc_i[1+COL_W +: ROW_W];
  assign pred_row   = mem_q[active_ctx_q][pred_idx];
  assign pred_blank = copy_busy & (active_ctx_q == copy_dst);

  always_comb begin
    bht_prediction_o = '0;
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      bht_prediction_o[i].valid = pred_row[i].valid & ~pred_blank;
      bht_prediction_o[i].taken = pred_row[i].ctr[1];
    end
  end

  logic unused_pc;
  assign unused_pc = ^{vpc_i, update_q.pc};

  assign copy_busy_o  = copy_busy;
  assign copy_done_o  = copy_done;
  assign active_ctx_o = active_ctx_q;

`ifdef BHT_CTX_PERF_EN
  logic [NR_CTX-1:0][15:0] perf_upd_q;
  logic [15:0]             perf_copy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_upd_q  <= '0;
      perf_copy_q <= '0;
    end else begin
      if (upd_en && (perf_upd_q[ctx_q] != 16'hFFFF)) begin
        perf_upd_q[ctx_q] <= perf_upd_q[ctx_q] + 16'd1;
      end
      if (copy_done && (perf_copy_q != 16'hFFFF)) begin
        perf_copy_q <= perf_copy_q + 16'd1;
      end
    end
  end

  assign perf_upd_cnt_o  = perf_upd_q;
  assign perf_copy_cnt_o = perf_copy_q;
`endif

endmodule
